hv_timing_gen: RTL and testbench
================================

Name: hv_timing_gen

Overview:
- Parametrised raster timing generator for arcade cores: pixel clock-enable driven H/V counters, active-area pixel coordinates, blanking, active-low syncs and blank-gated RGB output.
- Successor to the fixed 384x263 generator. Geometry is set by parameters. Counting is linear, with no counter-jump tricks.
- Sync placement is adjustable per frame, and offset changes are applied glitch-free at frame boundaries.
- Sits between the game core's pixel output and the arcade video / scandoubler path.

Parameters:
- CNT_W, 9: width of the H/V counters, hpos and vpos.
- RGB_W, 12: colour bus width.
- H_TOTAL, 384: pixel clocks per line.
- H_ACT_BEG, 24: first active hcnt.
- H_ACT_LEN, 242: number of active pixels per line.
- H_SYNC_BEG, 288: base hsync start hcnt.
- H_SYNC_LEN, 32: hsync width in pixel clocks.
- V_TOTAL, 263: lines per frame.
- V_ACT_BEG, 0: first active line.
- V_ACT_LEN, 224: number of active lines.
- V_SYNC_BEG, 226: base vsync start line.
- V_SYNC_LEN, 6: vsync width in lines.
- HOFFS_W, 5: width of the hoffs input.
- VOFFS_W, 3: width of the voffs input.
- HOFFS_STEP, 2: pixel clocks per hoffs unit.
- VOFFS_STEP, 4: lines per voffs unit.

Ports:
- clk_sys, in, 1: system clock. All logic is on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- ce_pix, in, 1: pixel clock enable. State advances only when it is 1.
- hoffs, in, HOFFS_W: hsync position offset.
- voffs, in, VOFFS_W: vsync position offset.
- rgb_in, in, RGB_W: pixel colour from the core for the current hpos/vpos.
- hpos, out, CNT_W: hcnt-H_ACT_BEG, mod 2^CNT_W (combinational from the counter).
- vpos, out, CNT_W: vcnt-V_ACT_BEG, mod 2^CNT_W (combinational from the counter).
- hblank, out, 1: registered horizontal blank.
- vblank, out, 1: registered vertical blank.
- hsync_n, out, 1: registered hsync, active low.
- vsync_n, out, 1: registered vsync, active low.
- de, out, 1: registered ~(hblank|vblank).
- rgb_out, out, RGB_W: registered RGB, forced to 0 while blanked.
- line_start, out, 1: one-ce pulse registered from hcnt==0.
- frame_start, out, 1: one-ce pulse registered from hcnt==0 && vcnt==0.

Behaviour:
- Reset values:
  - hcnt=0, vcnt=0, latched offsets=0.
  - hblank=1, vblank=1, hsync_n=1, vsync_n=1.
  - de=0, rgb_out=0, line_start=0, frame_start=0.
- Reset asserted mid-line takes effect immediately, regardless of ce_pix.
- Counters (on ce_pix only):
  - hcnt increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, vcnt increments and wraps from V_TOTAL-1 to 0.
- ce_pix=0: all registers hold, and pulses hold their value. The driver guarantees ce_pix is at least 2 clk_sys apart.
- Offset latch: hoffs/voffs are captured into hoffs_l/voffs_l on the ce where hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1. Changes made mid-frame never move sync within the current frame.
- Sync start positions:
  - hs_start = (H_SYNC_BEG + hoffs_l*HOFFS_STEP) mod H_TOTAL.
  - vs_start = (V_SYNC_BEG + voffs_l*VOFFS_STEP) mod V_TOTAL.
  - Arithmetic is CNT_W+2 bits wide. The mod is a single conditional subtract; parameters guarantee the sum is < 2*TOTAL.
- Sync active conditions:
  - hs_act when ((hcnt - hs_start) mod H_TOTAL) < H_SYNC_LEN. This handles wrap past end of line.
  - vs_act is the same form, using vcnt and vs_start. vsync changes on line boundaries only, at hcnt==0.
- Blank conditions:
  - hb = !(H_ACT_BEG <= hcnt < H_ACT_BEG+H_ACT_LEN).
  - vb is the same form on vcnt with V_ACT_BEG and V_ACT_LEN.
- Registered outputs (on ce): hblank<=hb, vblank<=vb, hsync_n<=~hs_act, vsync_n<=~vs_act, de<=~(hb|vb), rgb_out<=(hb|vb)?0:rgb_in.
- Latency: all registered outputs lag the counter by exactly one ce. hpos/vpos have no lag, so the core has one ce to return rgb_in.
- Parameter legality: H_ACT_BEG+H_ACT_LEN <= H_TOTAL, SYNC_LEN < TOTAL, TOTAL <= 2^CNT_W. Violations fail elaboration via a generate-time check.

Optional Feature:
- Macro: HV_TIMING_GEN_FLIP_EN.
- When defined:
  - Adds an input port flip (1 bit), sampled with the offsets at frame wrap.
  - When the latched flip is 1, hpos = H_ACT_LEN-1-(hcnt-H_ACT_BEG) and vpos = V_ACT_LEN-1-(vcnt-V_ACT_BEG), each mod 2^CNT_W.
  - Timing and sync are unchanged.
- When undefined: no flip port exists, and hpos/vpos are as above.

Test Plan:
- Defaults, ce_pix every 8th clk, after reset:
  - hsync_n low for exactly 32 ce, first low ce is the one after hcnt=288.
  - Line period is 384 ce; frame period is 100992 ce.
  - vsync_n is low on lines 226..231.
- hoffs=31 and voffs=7 applied before a frame wrap: next frame hsync covers hcnt 350..381 and vsync covers lines 254..259. Changing them at vcnt=100 leaves the current frame unchanged.
- Override H_SYNC_BEG=370: hsync_n is low for hcnt 370..383 and 0..17 (32 ce, continuous across the line wrap).
- rgb_in=12'hABC held:
  - rgb_out=0 and hblank=1 for the ce registering hcnt=23.
  - rgb_out=ABC, de=1 for hcnt=24.
  - rgb_out returns to 0 at hcnt=266, and during vcnt=224..262.
- Reset pulsed asynchronously at hcnt=200, vcnt=50: outputs immediately return to their reset values. After release, frame_start pulses on the first ce, and the hpos sequence restarts at 0-24 = 9'h1E8.
- With HV_TIMING_GEN_FLIP_EN and flip=1 latched: at hcnt=24, vcnt=0, hpos=241 and vpos=223. The sync waveform is identical to the flip=0 run.

Source files
------------

// File: rtl/hv_timing_gen_if.sv
// hv_timing_gen_if: video timing bus between the raster generator and the game core.
// master = timing generator side, slave = core / video path side.
// The flip input exists only when HV_TIMING_GEN_FLIP_EN is defined.
interface hv_timing_gen_if #(
    parameter int CNT_W   = 9,
    parameter int RGB_W   = 12,
    parameter int HOFFS_W = 5,
    parameter int VOFFS_W = 3
);
    logic               ce_pix;
    logic [HOFFS_W-1:0] hoffs;
    logic [VOFFS_W-1:0] voffs;
    logic [RGB_W-1:0]   rgb_in;
`ifdef HV_TIMING_GEN_FLIP_EN
    logic               flip;
`endif
    logic [CNT_W-1:0]   hpos;
    logic [CNT_W-1:0]   vpos;
    logic               hblank;
    logic               vblank;
    logic               hsync_n;
    logic               vsync_n;
    logic               de;
    logic [RGB_W-1:0]   rgb_out;
    logic               line_start;
    logic               frame_start;

    modport master (
        input  ce_pix, hoffs, voffs, rgb_in,
`ifdef HV_TIMING_GEN_FLIP_EN
        input  flip,
`endif
        output hpos, vpos, hblank, vblank, hsync_n, vsync_n, de, rgb_out,
               line_start, frame_start
    );

    modport slave (
        output ce_pix, hoffs, voffs, rgb_in,
`ifdef HV_TIMING_GEN_FLIP_EN
        output flip,
`endif
        input  hpos, vpos, hblank, vblank, hsync_n, vsync_n, de, rgb_out,
               line_start, frame_start
    );
endinterface

// File: rtl/hv_timing_gen.sv
// hv_timing_gen: parametrised raster timing generator for arcade cores.
// Linear H/V counters advanced by ce_pix, active-area coordinates, registered
// blanking, active-low syncs with per-frame offsets and blank-gated RGB.
// Optional feature macro: HV_TIMING_GEN_FLIP_EN (adds flip input that mirrors hpos/vpos).
module hv_timing_gen #(
    parameter int CNT_W      = 9,
    parameter int RGB_W      = 12,
    parameter int H_TOTAL    = 384,
    parameter int H_ACT_BEG  = 24,
    parameter int H_ACT_LEN  = 242,
    parameter int H_SYNC_BEG = 288,
    parameter int H_SYNC_LEN = 32,
    parameter int V_TOTAL    = 263,
    parameter int V_ACT_BEG  = 0,
    parameter int V_ACT_LEN  = 224,
    parameter int V_SYNC_BEG = 226,
    parameter int V_SYNC_LEN = 6,
    parameter int HOFFS_W    = 5,
    parameter int VOFFS_W    = 3,
    parameter int HOFFS_STEP = 2,
    parameter int VOFFS_STEP = 4
) (
    input  logic            clk_sys,
    input  logic            reset,
    hv_timing_gen_if.master bus
);
    // Two spare bits so offset sums and wrapped differences never overflow.
    localparam int AW = CNT_W + 2;

    generate
        if ((H_ACT_BEG + H_ACT_LEN > H_TOTAL) || (V_ACT_BEG + V_ACT_LEN > V_TOTAL) ||
            (H_SYNC_LEN >= H_TOTAL) || (V_SYNC_LEN >= V_TOTAL) ||
            (H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_params
            $error("hv_timing_gen: illegal geometry parameters");
        end
    endgenerate

    logic [CNT_W-1:0]   hcnt;
    logic [CNT_W-1:0]   vcnt;
    logic [HOFFS_W-1:0] hoffs_l;
    logic [VOFFS_W-1:0] voffs_l;
`ifdef HV_TIMING_GEN_FLIP_EN
    logic               flip_l;
`endif

    logic h_last;
    logic v_last;
    assign h_last = (hcnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (vcnt == CNT_W'(V_TOTAL - 1));

    // Sync start = base + scaled offset, folded back into the line/frame once.
    logic [AW-1:0] hs_sum, hs_start, hs_raw, hs_dist;
    logic [AW-1:0] vs_sum, vs_start, vs_raw, vs_dist;
    logic          hs_act, vs_act;

    assign hs_sum   = AW'(H_SYNC_BEG) + AW'(hoffs_l) * AW'(HOFFS_STEP);
    assign hs_start = (hs_sum >= AW'(H_TOTAL)) ? hs_sum - AW'(H_TOTAL) : hs_sum;
    assign vs_sum   = AW'(V_SYNC_BEG) + AW'(voffs_l) * AW'(VOFFS_STEP);
    assign vs_start = (vs_sum >= AW'(V_TOTAL)) ? vs_sum - AW'(V_TOTAL) : vs_sum;

    // Distance past the sync start, modulo the total, so a pulse may wrap the line/frame.
    assign hs_raw  = AW'(hcnt) - hs_start;
    assign hs_dist = hs_raw[AW-1] ? hs_raw + AW'(H_TOTAL) : hs_raw;
    assign hs_act  = (hs_dist < AW'(H_SYNC_LEN));
    assign vs_raw  = AW'(vcnt) - vs_start;
    assign vs_dist = vs_raw[AW-1] ? vs_raw + AW'(V_TOTAL) : vs_raw;
    assign vs_act  = (vs_dist < AW'(V_SYNC_LEN));

    // Active window test via an unsigned offset: counts before the start wrap to huge values.
    logic [AW-1:0] h_rel, v_rel;
    logic          hb, vb;
    assign h_rel = AW'(hcnt) - AW'(H_ACT_BEG);
    assign v_rel = AW'(vcnt) - AW'(V_ACT_BEG);
    assign hb    = !(h_rel < AW'(H_ACT_LEN));
    assign vb    = !(v_rel < AW'(V_ACT_LEN));

    // Pixel coordinates come straight from the counters so the core gets a full ce to respond.
    logic [CNT_W-1:0] hpos_lin, vpos_lin;
    assign hpos_lin = hcnt - CNT_W'(H_ACT_BEG);
    assign vpos_lin = vcnt - CNT_W'(V_ACT_BEG);
`ifdef HV_TIMING_GEN_FLIP_EN
    assign bus.hpos = flip_l ? CNT_W'(H_ACT_LEN - 1) - hpos_lin : hpos_lin;
    assign bus.vpos = flip_l ? CNT_W'(V_ACT_LEN - 1) - vpos_lin : vpos_lin;
`else
    assign bus.hpos = hpos_lin;
    assign bus.vpos = vpos_lin;
`endif

    // Raster counters: hcnt wraps each line and carries into vcnt.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (bus.ce_pix) begin
            if (h_last) begin
                hcnt <= '0;
                vcnt <= v_last ? '0 : vcnt + CNT_W'(1);
            end else begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end
    end

    // Offsets are only taken on the last pixel of a frame so sync never moves mid-frame.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hoffs_l <= '0;
            voffs_l <= '0;
`ifdef HV_TIMING_GEN_FLIP_EN
            flip_l  <= 1'b0;
`endif
        end else if (bus.ce_pix && h_last && v_last) begin
            hoffs_l <= bus.hoffs;
            voffs_l <= bus.voffs;
`ifdef HV_TIMING_GEN_FLIP_EN
            flip_l  <= bus.flip;
`endif
        end
    end

    logic             hblank_r, vblank_r, hsync_n_r, vsync_n_r, de_r;
    logic             line_start_r, frame_start_r;
    logic [RGB_W-1:0] rgb_out_r;

    // Video outputs lag the counters by one ce; everything holds while ce_pix is low.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hblank_r      <= 1'b1;
            vblank_r      <= 1'b1;
            hsync_n_r     <= 1'b1;
            vsync_n_r     <= 1'b1;
            de_r          <= 1'b0;
            rgb_out_r     <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (bus.ce_pix) begin
            hblank_r      <= hb;
            vblank_r      <= vb;
            hsync_n_r     <= ~hs_act;
            vsync_n_r     <= ~vs_act;
            de_r          <= ~(hb | vb);
            rgb_out_r     <= (hb | vb) ? '0 : bus.rgb_in;
            line_start_r  <= (hcnt == '0);
            frame_start_r <= (hcnt == '0) && (vcnt == '0);
        end
    end

    assign bus.hblank      = hblank_r;
    assign bus.vblank      = vblank_r;
    assign bus.hsync_n     = hsync_n_r;
    assign bus.vsync_n     = vsync_n_r;
    assign bus.de          = de_r;
    assign bus.rgb_out     = rgb_out_r;
    assign bus.line_start  = line_start_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_hv_timing_gen.sv
// tb_hv_timing_gen: directed bench for hv_timing_gen.
// Horizontal geometry is the default 384-clock line (HOFFS_STEP=3 so hoffs=31 wraps
// the hsync pulse across the line end); the frame is shortened to 12 lines
// (active 1..8, vsync base 9, 2 lines, VOFFS_STEP=1) so several frames fit in a short run.
// h/v below track where the DUT counters are after each ce; registered outputs show
// the position one ce earlier.
module tb_hv_timing_gen;
    localparam int CNT_W   = 9;
    localparam int RGB_W   = 12;
    localparam int HOFFS_W = 5;
    localparam int VOFFS_W = 3;
    localparam int HT      = 384;
    localparam int VT      = 12;

    logic clk_sys = 1'b0;
    logic reset;

    hv_timing_gen_if #(.CNT_W(CNT_W), .RGB_W(RGB_W), .HOFFS_W(HOFFS_W), .VOFFS_W(VOFFS_W)) bus ();

    hv_timing_gen #(
        .CNT_W(CNT_W), .RGB_W(RGB_W),
        .H_TOTAL(HT), .H_ACT_BEG(24), .H_ACT_LEN(242), .H_SYNC_BEG(288), .H_SYNC_LEN(32),
        .V_TOTAL(VT), .V_ACT_BEG(1), .V_ACT_LEN(8), .V_SYNC_BEG(9), .V_SYNC_LEN(2),
        .HOFFS_W(HOFFS_W), .VOFFS_W(VOFFS_W), .HOFFS_STEP(3), .VOFFS_STEP(1)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk_sys = ~clk_sys;

    int h = 0;
    int v = 0;
    int vectors = 0;
    int miscompares = 0;

    // Count one comparison and report it when observed and expected disagree.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, got, exp, h, v);
        end
    endtask

    // One pixel clock enable, one clk_sys wide, followed by an idle clk_sys.
    task automatic applyStimulus();
        @(negedge clk_sys);
        bus.ce_pix = 1'b1;
        @(negedge clk_sys);
        bus.ce_pix = 1'b0;
        h++;
        if (h == HT) begin
            h = 0;
            v++;
            if (v == VT) v = 0;
        end
    endtask

    task automatic advanceTo(input int th, input int tv);
        int n;
        n = 0;
        while (!(h == th && v == tv) && n < 10000) begin
            applyStimulus();
            n++;
        end
        if (n >= 10000) checkOutput("advance_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        bus.ce_pix  = 1'b0;
        bus.hoffs   = '0;
        bus.voffs   = '0;
        bus.rgb_in  = 12'hABC;
`ifdef HV_TIMING_GEN_FLIP_EN
        bus.flip    = 1'b0;
`endif
        repeat (3) @(negedge clk_sys);

        $display("[TB] reset state");
        checkOutput("rst_hblank",  32'(bus.hblank), 32'd1);
        checkOutput("rst_vblank",  32'(bus.vblank), 32'd1);
        checkOutput("rst_hsync_n", 32'(bus.hsync_n), 32'd1);
        checkOutput("rst_vsync_n", 32'(bus.vsync_n), 32'd1);
        checkOutput("rst_de",      32'(bus.de), 32'd0);
        checkOutput("rst_rgb",     32'(bus.rgb_out), 32'd0);
        checkOutput("rst_line",    32'(bus.line_start), 32'd0);
        checkOutput("rst_frame",   32'(bus.frame_start), 32'd0);
        checkOutput("rst_hpos",    32'(bus.hpos), 32'h1E8);
        checkOutput("rst_vpos",    32'(bus.vpos), 32'h1FF);

        reset = 1'b0;
        @(negedge clk_sys);

        $display("[TB] first ce after reset");
        applyStimulus();
        checkOutput("first_frame_start", 32'(bus.frame_start), 32'd1);
        checkOutput("first_line_start",  32'(bus.line_start), 32'd1);
        checkOutput("first_hpos",        32'(bus.hpos), 32'h1E9);
        checkOutput("first_hsync_n",     32'(bus.hsync_n), 32'd1);
        checkOutput("first_vsync_n",     32'(bus.vsync_n), 32'd1);
        checkOutput("first_de",          32'(bus.de), 32'd0);
        repeat (2) @(negedge clk_sys);
        checkOutput("pulse_hold",        32'(bus.frame_start), 32'd1);
        applyStimulus();
        checkOutput("pulse_end_frame",   32'(bus.frame_start), 32'd0);
        checkOutput("pulse_end_line",    32'(bus.line_start), 32'd0);

        $display("[TB] base hsync window 288..319");
        advanceTo(288, 0); checkOutput("hs_before_287", 32'(bus.hsync_n), 32'd1);
        advanceTo(289, 0); checkOutput("hs_first_288",  32'(bus.hsync_n), 32'd0);
        advanceTo(320, 0); checkOutput("hs_last_319",   32'(bus.hsync_n), 32'd0);
        advanceTo(321, 0); checkOutput("hs_after_320",  32'(bus.hsync_n), 32'd1);

        $display("[TB] active window and rgb gating");
        advanceTo(1, 1);
        checkOutput("line1_line_start",  32'(bus.line_start), 32'd1);
        checkOutput("line1_frame_start", 32'(bus.frame_start), 32'd0);
        checkOutput("line1_vblank",      32'(bus.vblank), 32'd0);
        checkOutput("line1_vpos",        32'(bus.vpos), 32'd0);
        advanceTo(24, 1);
        checkOutput("h23_rgb",    32'(bus.rgb_out), 32'd0);
        checkOutput("h23_hblank", 32'(bus.hblank), 32'd1);
        checkOutput("h23_de",     32'(bus.de), 32'd0);
        checkOutput("h24_hpos",   32'(bus.hpos), 32'd0);
        advanceTo(25, 1);
        checkOutput("h24_rgb",    32'(bus.rgb_out), 32'h0ABC);
        checkOutput("h24_de",     32'(bus.de), 32'd1);
        checkOutput("h24_hblank", 32'(bus.hblank), 32'd0);
        checkOutput("h25_hpos",   32'(bus.hpos), 32'd1);
        advanceTo(266, 1); checkOutput("h265_rgb", 32'(bus.rgb_out), 32'h0ABC);
        advanceTo(267, 1);
        checkOutput("h266_rgb",    32'(bus.rgb_out), 32'd0);
        checkOutput("h266_hblank", 32'(bus.hblank), 32'd1);

        $display("[TB] offsets changed mid-frame");
        advanceTo(0, 3);
        bus.hoffs = 5'd31;
        bus.voffs = 3'd2;
`ifdef HV_TIMING_GEN_FLIP_EN
        bus.flip  = 1'b1;
`endif
        advanceTo(289, 4); checkOutput("mid_hs_288", 32'(bus.hsync_n), 32'd0);
        advanceTo(382, 4); checkOutput("mid_hs_381", 32'(bus.hsync_n), 32'd1);
        advanceTo(0, 9);
        checkOutput("v8_vsync_n", 32'(bus.vsync_n), 32'd1);
        checkOutput("v8_vblank",  32'(bus.vblank), 32'd0);
        advanceTo(1, 9);
        checkOutput("v9_vsync_n", 32'(bus.vsync_n), 32'd0);
        checkOutput("v9_vblank",  32'(bus.vblank), 32'd1);
        checkOutput("v9_vpos",    32'(bus.vpos), 32'd8);
        advanceTo(100, 9);
        checkOutput("v9_rgb",     32'(bus.rgb_out), 32'd0);
        checkOutput("v9_de",      32'(bus.de), 32'd0);
        advanceTo(0, 11); checkOutput("v10_vsync_n", 32'(bus.vsync_n), 32'd0);
        advanceTo(1, 11); checkOutput("v11_vsync_n", 32'(bus.vsync_n), 32'd1);

        $display("[TB] next frame uses latched offsets");
        advanceTo(1, 0);
        checkOutput("f2_frame_start", 32'(bus.frame_start), 32'd1);
        checkOutput("f2_v0_vsync_n",  32'(bus.vsync_n), 32'd0);
        advanceTo(381, 0); checkOutput("f2_hs_380", 32'(bus.hsync_n), 32'd1);
        advanceTo(382, 0); checkOutput("f2_hs_381", 32'(bus.hsync_n), 32'd0);
        advanceTo(1, 1);
        checkOutput("f2_hs_wrap_0",  32'(bus.hsync_n), 32'd0);
        checkOutput("f2_v1_vsync_n", 32'(bus.vsync_n), 32'd1);
        advanceTo(24, 1);
`ifdef HV_TIMING_GEN_FLIP_EN
        checkOutput("f2_flip_hpos", 32'(bus.hpos), 32'd241);
        checkOutput("f2_flip_vpos", 32'(bus.vpos), 32'd7);
`else
        checkOutput("f2_hpos", 32'(bus.hpos), 32'd0);
        checkOutput("f2_vpos", 32'(bus.vpos), 32'd0);
`endif
        advanceTo(29, 1); checkOutput("f2_hs_28", 32'(bus.hsync_n), 32'd0);
        advanceTo(30, 1); checkOutput("f2_hs_29", 32'(bus.hsync_n), 32'd1);

        $display("[TB] asynchronous reset mid-line");
        advanceTo(200, 5);
        checkOutput("pre_rst_de",  32'(bus.de), 32'd1);
        checkOutput("pre_rst_rgb", 32'(bus.rgb_out), 32'h0ABC);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_de",      32'(bus.de), 32'd0);
        checkOutput("arst_rgb",     32'(bus.rgb_out), 32'd0);
        checkOutput("arst_hblank",  32'(bus.hblank), 32'd1);
        checkOutput("arst_vblank",  32'(bus.vblank), 32'd1);
        checkOutput("arst_hpos",    32'(bus.hpos), 32'h1E8);
        checkOutput("arst_vpos",    32'(bus.vpos), 32'h1FF);
        h = 0;
        v = 0;
        @(negedge clk_sys);
        reset = 1'b0;
        applyStimulus();
        checkOutput("rel_frame_start", 32'(bus.frame_start), 32'd1);
        checkOutput("rel_hpos",        32'(bus.hpos), 32'h1E9);
        advanceTo(24, 0);  checkOutput("rel_hpos_24", 32'(bus.hpos), 32'd0);
        advanceTo(289, 0); checkOutput("rel_hs_288",  32'(bus.hsync_n), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
